gshare_ctr_predictor: RTL and testbench
=======================================

// Module: gshare_ctr_predictor
// PURPOSE
//  Parametrised gshare direction predictor for fetch: NUM_LANES predict lanes, NUM_LANES update lanes.
//  Table of 2^INDEX_BITS saturating CTR_BITS counters, plus a speculative global history register (GHR).
//  Predict path returns a snapshot of the history used. Feedback supplies it back for checkpoint recovery.
//  After reset, an init sweep clears the table. Sits beside the BTB in fetch and drives fetch stall while busy.
// PARAMETERS
//  HISTORY_WIDTH  10  GHR bits; must be <= INDEX_BITS
//  INDEX_BITS     12  table index bits; depth = 2^INDEX_BITS
//  CTR_BITS       2   counter width (>=1); prediction = counter MSB
//  NUM_LANES      2   predict lanes and update lanes (>=1)
//  PC_LSB         2   lowest PC bit used in the index
// PORTS
//  clk              in   1            clock, rising edge
//  reset            in   1            asynchronous, active-high
//  pred_valid[L]    in   1            lane L requests a prediction
//  pred_pc[L]       in   ADDR_WIDTH   branch PC
//  pred_is_br[L]    in   1            lane holds a conditional branch (shifts GHR)
//  resp_valid[L]    out  1            response for the request of the previous cycle
//  resp_taken[L]    out  1            predicted direction
//  resp_ctr[L]      out  CTR_BITS     counter value read
//  resp_hist[L]     out  HISTORY_WIDTH GHR snapshot used for the index
//  upd_valid[L]     in   1            resolved-branch feedback
//  upd_pc[L]        in   ADDR_WIDTH   branch PC
//  upd_hist[L]      in   HISTORY_WIDTH resp_hist returned with the branch
//  upd_ctr[L]       in   CTR_BITS     resp_ctr returned with the branch
//  upd_taken[L]     in   1            actual outcome
//  upd_mispredict[L] in  1            direction mispredicted; triggers GHR recovery
//  busy             out  1            init sweep in progress; fetch must stall
// BEHAVIOUR
//  Index: idx = pred_pc[INDEX_BITS+PC_LSB-1:PC_LSB] ^ zero-extended GHR.
//   The update path uses upd_pc with upd_hist instead.
//  Reset values: GHR=0, busy=1, FSM=INIT, init_ptr=0; all resp_* are 0.
//  FSM INIT: each cycle writes WEAK_NT (2^(CTR_BITS-1)-1; 0 if CTR_BITS=1) to entry init_ptr, then increments it.
//   After the write of entry 2^INDEX_BITS-1 -> READY; busy falls on that same edge.
//  In INIT: pred_valid/upd_valid are ignored, resp_valid=0, GHR holds.
//  Reset asserted mid-sweep or in READY: immediately back to INIT with init_ptr=0 and a full sweep restarts.
//  READY, predict: 1-cycle latency. A request accepted at edge N gives resp_* valid in cycle N+1.
//   resp_valid is a single-cycle pulse; no backpressure.
//  All lanes in a cycle index with the same start-of-cycle GHR; resp_hist = that GHR.
//  Speculative shift: for lanes in ascending order with pred_valid & pred_is_br, GHR = {GHR[W-2:0], predicted bit}.
//   The predicted bit is the counter MSB read that cycle (combinational read for the GHR path, registered for resp).
//  Update: write sat(upd_ctr +1) if upd_taken, else sat(upd_ctr -1), to the index.
//   Saturates at 0 and 2^CTR_BITS-1. Writes are blind (no read-modify-write).
//  Write collision (two update lanes, same index): the highest-numbered lane wins.
//  Read/write same index, same cycle: the read returns the pre-write value (read-first).
//  Recovery: if any upd_valid & upd_mispredict, the lowest such lane L sets GHR = {upd_hist[L][W-2:0], upd_taken[L]}.
//   This overrides that cycle's speculative shift. Table predictions that cycle still respond normally.
//  pred_valid with pred_is_br=0: predicts, does not shift GHR.
// TESTING
//  Reset with INDEX_BITS=4 -> busy=1 for exactly 16 cycles; every entry reads 1 (CTR_BITS=2); resp_valid stays 0 during the sweep.
//  Same index, 3 updates taken from upd_ctr 1 -> stored 2, then 3, then 3 (saturated); 4 not-taken from 3 -> stored 0 (saturated).
//  Lanes 0,1 both branches, GHR=0; lane0 reads 2, lane1 reads 0 -> GHR=0b10 next cycle; both resp_hist=0.
//  Mispredict on lanes 0 and 1 same cycle, upd_hist[0]=0x155, taken=0 -> GHR=0x2AA (lane0 wins, spec shift dropped).
//  Two update lanes write the same index with values 3 and 0 -> entry=0. Predict of that index same cycle -> old value.
//  Reset asserted at init_ptr=7 -> sweep restarts from 0; busy stays high a further 16 cycles after reset release.

Source files
------------

// File: rtl/gshare_ctr_predictor.sv
// rtl/gshare_ctr_predictor.sv - multi-lane gshare direction predictor with speculative GHR and init sweep
// Table of saturating counters indexed by PC xor global history; clears itself after every reset.
module gshare_ctr_predictor #(
  parameter int HISTORY_WIDTH = 10,
  parameter int INDEX_BITS    = 12,
  parameter int CTR_BITS      = 2,
  parameter int NUM_LANES     = 2,
  parameter int PC_LSB        = 2,
  parameter int ADDR_WIDTH    = 32
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_LANES-1:0]                       pred_valid,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]       pred_pc,
  input  logic [NUM_LANES-1:0]                       pred_is_br,
  output logic [NUM_LANES-1:0]                       resp_valid,
  output logic [NUM_LANES-1:0]                       resp_taken,
  output logic [NUM_LANES-1:0][CTR_BITS-1:0]         resp_ctr,
  output logic [NUM_LANES-1:0][HISTORY_WIDTH-1:0]    resp_hist,
  input  logic [NUM_LANES-1:0]                       upd_valid,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]       upd_pc,
  input  logic [NUM_LANES-1:0][HISTORY_WIDTH-1:0]    upd_hist,
  input  logic [NUM_LANES-1:0][CTR_BITS-1:0]         upd_ctr,
  input  logic [NUM_LANES-1:0]                       upd_taken,
  input  logic [NUM_LANES-1:0]                       upd_mispredict,
  output logic                                       busy
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                                  state;
  logic [INDEX_BITS-1:0]                   init_ptr;
  logic [HISTORY_WIDTH-1:0]                ghr;
  logic [HISTORY_WIDTH-1:0]                ghr_next;
  logic [CTR_BITS-1:0]                     table_mem [DEPTH];
  logic [NUM_LANES-1:0][INDEX_BITS-1:0]    pred_idx;
  logic [NUM_LANES-1:0][INDEX_BITS-1:0]    upd_idx;
  logic [NUM_LANES-1:0][CTR_BITS-1:0]      pred_rd;
  logic [NUM_LANES-1:0][CTR_BITS-1:0]      upd_wr;

  function automatic logic [INDEX_BITS-1:0] make_idx(input logic [ADDR_WIDTH-1:0] pc,
                                                     input logic [HISTORY_WIDTH-1:0] hist);
    return pc[INDEX_BITS+PC_LSB-1:PC_LSB] ^ INDEX_BITS'(hist);
  endfunction

  function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_MAX) ? ctr : ctr + CTR_BITS'(1);
    return (ctr == '0) ? ctr : ctr - CTR_BITS'(1);
  endfunction

  always_comb begin
    pred_idx = '0;
    upd_idx  = '0;
    pred_rd  = '0;
    upd_wr   = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      pred_idx[l] = make_idx(pred_pc[l], ghr);
      pred_rd[l]  = table_mem[pred_idx[l]];
      upd_idx[l]  = make_idx(upd_pc[l], upd_hist[l]);
      upd_wr[l]   = sat_step(upd_ctr[l], upd_taken[l]);
    end
  end

  // Lanes shift in order; the lowest mispredicting update lane then overrides everything.
  always_comb begin
    ghr_next = ghr;
    for (int l = 0; l < NUM_LANES; l++)
      if (pred_valid[l] && pred_is_br[l])
        ghr_next = HISTORY_WIDTH'({ghr_next, pred_rd[l][CTR_BITS-1]});
    for (int l = NUM_LANES - 1; l >= 0; l--)
      if (upd_valid[l] && upd_mispredict[l])
        ghr_next = HISTORY_WIDTH'({upd_hist[l], upd_taken[l]});
  end

  // Later lanes are written last, so the highest-numbered lane wins a collision.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      table_mem[init_ptr] <= WEAK_NT;
    end else begin
      for (int l = 0; l < NUM_LANES; l++)
        if (upd_valid[l]) table_mem[upd_idx[l]] <= upd_wr[l];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      init_ptr   <= '0;
      busy       <= 1'b1;
      ghr        <= '0;
      resp_valid <= '0;
      resp_taken <= '0;
      resp_ctr   <= '0;
      resp_hist  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          resp_valid <= '0;
          init_ptr   <= init_ptr + INDEX_BITS'(1);
          if (&init_ptr) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end
        end
        default: begin
          ghr        <= ghr_next;
          resp_valid <= pred_valid;
          for (int l = 0; l < NUM_LANES; l++) begin
            resp_taken[l] <= pred_valid[l] & pred_rd[l][CTR_BITS-1];
            resp_ctr[l]   <= pred_valid[l] ? pred_rd[l] : '0;
            resp_hist[l]  <= pred_valid[l] ? ghr : '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gshare_ctr_predictor.sv
// tb/tb_gshare_ctr_predictor.sv - self-checking bench for gshare_ctr_predictor
// Directed vector table, reset/sweep sequences and randomized traffic against an array model.
module tb_gshare_ctr_predictor;

  localparam int HW = 10;
  localparam int IB = 10;
  localparam int CB = 2;
  localparam int NL = 2;
  localparam int PL = 2;
  localparam int AW = 32;
  localparam int DEPTH = 1 << IB;
  localparam int HMASK = (1 << HW) - 1;
  localparam int CMAX = (1 << CB) - 1;

  logic                    clk;
  logic                    reset;
  logic [NL-1:0]           pred_valid, pred_is_br, resp_valid, resp_taken;
  logic [NL-1:0][AW-1:0]   pred_pc, upd_pc;
  logic [NL-1:0][CB-1:0]   resp_ctr, upd_ctr;
  logic [NL-1:0][HW-1:0]   resp_hist, upd_hist;
  logic [NL-1:0]           upd_valid, upd_taken, upd_mispredict;
  logic                    busy;

  int checks = 0;
  int errors = 0;
  int m_tbl [DEPTH];
  int m_ghr;

  gshare_ctr_predictor #(
    .HISTORY_WIDTH(HW), .INDEX_BITS(IB), .CTR_BITS(CB),
    .NUM_LANES(NL), .PC_LSB(PL), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_is_br(pred_is_br),
    .resp_valid(resp_valid), .resp_taken(resp_taken), .resp_ctr(resp_ctr), .resp_hist(resp_hist),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist), .upd_ctr(upd_ctr),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] pv, pbr;
    int         p0, p1;
    logic [1:0] uv, ut, um;
    int         u0, u1, h0, h1, c0, c1;
    logic [1:0] ev;
    int         e0, e1, eh0, eh1;
  } vec_t;

  function automatic vec_t mkv(logic [1:0] pv, logic [1:0] pbr, int p0, int p1,
                               logic [1:0] uv, logic [1:0] ut, logic [1:0] um,
                               int u0, int u1, int h0, int h1, int c0, int c1,
                               logic [1:0] ev, int e0, int e1, int eh0, int eh1);
    vec_t v;
    v.pv = pv; v.pbr = pbr; v.p0 = p0; v.p1 = p1;
    v.uv = uv; v.ut = ut; v.um = um; v.u0 = u0; v.u1 = u1;
    v.h0 = h0; v.h1 = h1; v.c0 = c0; v.c1 = c1;
    v.ev = ev; v.e0 = e0; v.e1 = e1; v.eh0 = eh0; v.eh1 = eh1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [AW-1:0] pc, input int h);
    return int'(((pc >> PL) ^ 32'(h)) & 32'(DEPTH - 1));
  endfunction

  task automatic idle();
    pred_valid = '0; pred_is_br = '0; pred_pc = '0;
    upd_valid = '0; upd_taken = '0; upd_mispredict = '0;
    upd_pc = '0; upd_hist = '0; upd_ctr = '0;
  endtask

  // One clock of traffic: predict expectations from the model, advance it, compare after the edge.
  task automatic step();
    logic [1:0] ev;
    int ec [NL];
    int eh, g, ix, c, nv;
    eh = m_ghr;
    g = m_ghr;
    for (int l = 0; l < NL; l++) begin
      ev[l] = pred_valid[l];
      ec[l] = m_tbl[idx_of(pred_pc[l], m_ghr)];
      if (pred_valid[l] && pred_is_br[l]) g = ((g << 1) | (ec[l] >> (CB - 1))) & HMASK;
    end
    for (int l = 0; l < NL; l++) begin
      if (upd_valid[l]) begin
        ix = idx_of(upd_pc[l], int'(upd_hist[l]));
        c = int'(upd_ctr[l]);
        nv = upd_taken[l] ? ((c == CMAX) ? CMAX : c + 1) : ((c == 0) ? 0 : c - 1);
        m_tbl[ix] = nv;
      end
    end
    for (int l = NL - 1; l >= 0; l--)
      if (upd_valid[l] && upd_mispredict[l]) g = ((int'(upd_hist[l]) << 1) | int'(upd_taken[l])) & HMASK;
    m_ghr = g;
    @(posedge clk); #1;
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("resp_valid%0d", l), 32'(resp_valid[l]), 32'(ev[l]));
      if (ev[l]) begin
        chk($sformatf("resp_ctr%0d", l), 32'(resp_ctr[l]), 32'(ec[l]));
        chk($sformatf("resp_taken%0d", l), 32'(resp_taken[l]), 32'(ec[l] >> (CB - 1)));
        chk($sformatf("resp_hist%0d", l), 32'(resp_hist[l]), 32'(eh));
      end
    end
  endtask

  // Called #1 after a posedge with reset just released; random traffic must be ignored.
  task automatic wait_sweep();
    int cnt;
    logic bad;
    cnt = 0;
    bad = 1'b0;
    while (busy && cnt < 5000) begin
      pred_valid = 2'($urandom); pred_is_br = 2'($urandom);
      pred_pc[0] = $urandom; pred_pc[1] = $urandom;
      upd_valid = 2'($urandom); upd_mispredict = 2'($urandom); upd_taken = 2'($urandom);
      upd_pc[0] = $urandom; upd_pc[1] = $urandom;
      upd_hist[0] = HW'($urandom); upd_hist[1] = HW'($urandom);
      @(posedge clk); #1;
      cnt++;
      if (resp_valid !== 2'b00) bad = 1'b1;
    end
    chk("busy_cycles", 32'(cnt), 32'(DEPTH));
    chk("resp_valid_during_init", 32'(bad), 32'd0);
    idle();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = (1 << (CB - 1)) - 1;
    m_ghr = 0;
  endtask

  task automatic read_all();
    for (int e = 0; e < DEPTH; e += 2) begin
      pred_valid = 2'b11; pred_is_br = 2'b00;
      pred_pc[0] = AW'(e << PL); pred_pc[1] = AW'((e + 1) << PL);
      step();
    end
    idle();
  endtask

  vec_t vecs [16];

  initial begin
    vecs[0]  = mkv(2'b00, 2'b00, 0, 0,         2'b01, 2'b01, 2'b00, 5, 0, 0, 0, 1, 0,  2'b00, 0, 0, 0, 0);
    vecs[1]  = mkv(2'b00, 2'b00, 0, 0,         2'b01, 2'b01, 2'b00, 5, 0, 0, 0, 2, 0,  2'b00, 0, 0, 0, 0);
    vecs[2]  = mkv(2'b00, 2'b00, 0, 0,         2'b01, 2'b01, 2'b00, 5, 0, 0, 0, 3, 0,  2'b00, 0, 0, 0, 0);
    vecs[3]  = mkv(2'b01, 2'b00, 5, 0,         2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b01, 3, 0, 0, 0);
    vecs[4]  = mkv(2'b00, 2'b00, 0, 0,         2'b01, 2'b00, 2'b00, 5, 0, 0, 0, 3, 0,  2'b00, 0, 0, 0, 0);
    vecs[5]  = mkv(2'b00, 2'b00, 0, 0,         2'b01, 2'b00, 2'b00, 5, 0, 0, 0, 2, 0,  2'b00, 0, 0, 0, 0);
    vecs[6]  = mkv(2'b00, 2'b00, 0, 0,         2'b01, 2'b00, 2'b00, 5, 0, 0, 0, 1, 0,  2'b00, 0, 0, 0, 0);
    vecs[7]  = mkv(2'b00, 2'b00, 0, 0,         2'b01, 2'b00, 2'b00, 5, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0, 0);
    vecs[8]  = mkv(2'b01, 2'b00, 5, 0,         2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b01, 0, 0, 0, 0);
    vecs[9]  = mkv(2'b00, 2'b00, 0, 0,         2'b01, 2'b01, 2'b00, 6, 0, 0, 0, 1, 0,  2'b00, 0, 0, 0, 0);
    vecs[10] = mkv(2'b11, 2'b11, 6, 5,         2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b11, 2, 0, 0, 0);
    vecs[11] = mkv(2'b11, 2'b00, 0, 4,         2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b11, 1, 2, 2, 2);
    vecs[12] = mkv(2'b01, 2'b01, 2, 0,         2'b11, 2'b10, 2'b11, 'h155, 'h0AB, 'h155, 'h0AA, 1, 1,
                   2'b01, 1, 0, 2, 0);
    vecs[13] = mkv(2'b11, 2'b00, 'h2AA, 'h2AB, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b11, 0, 2, 'h2AA, 'h2AA);
    vecs[14] = mkv(2'b01, 2'b00, 'h2AD, 0,     2'b11, 2'b01, 2'b00, 7, 7, 0, 0, 2, 1,  2'b01, 1, 0, 'h2AA, 0);
    vecs[15] = mkv(2'b01, 2'b00, 'h2AD, 0,     2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b01, 0, 0, 'h2AA, 0);

    clk = 1'b0;
    reset = 1'b1;
    idle();
    m_ghr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_ctr", 32'(resp_ctr), 32'd0);
    chk("reset_resp_hist", 32'(resp_hist), 32'd0);
    reset = 1'b0;
    wait_sweep();
    read_all();

    for (int i = 0; i < 16; i++) begin
      pred_valid = vecs[i].pv; pred_is_br = vecs[i].pbr;
      pred_pc[0] = AW'(vecs[i].p0 << PL); pred_pc[1] = AW'(vecs[i].p1 << PL);
      upd_valid = vecs[i].uv; upd_taken = vecs[i].ut; upd_mispredict = vecs[i].um;
      upd_pc[0] = AW'(vecs[i].u0 << PL); upd_pc[1] = AW'(vecs[i].u1 << PL);
      upd_hist[0] = HW'(vecs[i].h0); upd_hist[1] = HW'(vecs[i].h1);
      upd_ctr[0] = CB'(vecs[i].c0); upd_ctr[1] = CB'(vecs[i].c1);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(resp_valid), 32'(vecs[i].ev));
      if (vecs[i].ev[0]) begin
        chk($sformatf("vec%0d_ctr0", i), 32'(resp_ctr[0]), 32'(vecs[i].e0));
        chk($sformatf("vec%0d_hist0", i), 32'(resp_hist[0]), 32'(vecs[i].eh0));
      end
      if (vecs[i].ev[1]) begin
        chk($sformatf("vec%0d_ctr1", i), 32'(resp_ctr[1]), 32'(vecs[i].e1));
        chk($sformatf("vec%0d_hist1", i), 32'(resp_hist[1]), 32'(vecs[i].eh1));
      end
    end
    idle();

    // Reset mid-sweep at init_ptr=7: the whole sweep must restart.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midsweep_reset_busy", 32'(busy), 32'd1);
    chk("midsweep_reset_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_sweep();
    read_all();

    for (int n = 0; n < 1500; n++) begin
      pred_valid = 2'($urandom); pred_is_br = 2'($urandom);
      for (int l = 0; l < NL; l++) begin
        pred_pc[l] = $urandom;
        if ($urandom_range(0, 1) == 0) pred_pc[l][IB+PL-1:PL] = IB'($urandom_range(0, 31) ^ m_ghr);
        upd_pc[l] = $urandom;
        upd_pc[l][IB+PL-1:PL] = IB'($urandom_range(0, 31));
        upd_hist[l] = HW'($urandom_range(0, 31));
        upd_ctr[l] = CB'($urandom);
      end
      upd_valid = 2'($urandom); upd_taken = 2'($urandom);
      upd_mispredict = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      step();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
